// File: rtl/pulse_sched_pkg.sv
// rtl/pulse_sched_pkg.sv - shared types, defaults and round-robin pick for the pulse delay scheduler
package pulse_sched_pkg;

   localparam int DELAY_W_DEFAULT = 8;
   localparam int MAX_NREQ        = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_FIRE  = 2'd2
   } state_t;

   // First set bit of bitmap searching upward from last+1, wrapping at n.
   function automatic int rr_pick(input logic [MAX_NREQ-1:0] bitmap, input int last, input int n);
      int   pick;
      int   idx;
      logic found;
      pick  = 0;
      found = 1'b0;
      for (int k = 1; k <= MAX_NREQ; k++) begin
         idx = (last + k) % n;
         if (!found && k <= n && bitmap[idx[2:0]]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/req_sync_edge.sv
// rtl/req_sync_edge.sv - two-flop synchroniser with one-cycle rising-edge pulse
module req_sync_edge (
   input  logic out_clk,
   input  logic reset,
   input  logic level,
   output logic rise
);

   logic sync1;
   logic sync2;
   logic prev;

   always_ff @(posedge out_clk) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
      end else begin
         sync1 <= level;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign rise = sync2 & ~prev;

endmodule

// File: rtl/pulse_delay_scheduler.sv
// rtl/pulse_delay_scheduler.sv - round-robin scheduler sharing one delay counter among NREQ requesters
module pulse_delay_scheduler
   import pulse_sched_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int DELAY_W = DELAY_W_DEFAULT,
   parameter int IDW     = 2
) (
   input  logic                    out_clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req_async,
   input  logic [NREQ*DELAY_W-1:0] delay_cfg,
   input  logic                    ovf_clr,
   output logic [NREQ-1:0]         strobe,
   output logic [IDW-1:0]          strobe_id,
   output logic                    busy,
   output logic [NREQ-1:0]         pending,
   output logic [NREQ-1:0]         overflow
);

   state_t               state;
   state_t               state_next;
   logic [DELAY_W-1:0]   count;
   logic [DELAY_W-1:0]   count_next;
   logic [IDW-1:0]       last;
   logic [IDW-1:0]       last_next;
   logic [IDW-1:0]       grant_idx;
   logic [NREQ-1:0]      grant_mask;
   logic [NREQ-1:0]      rise;
   logic [NREQ-1:0]      strobe_next;
   logic [IDW-1:0]       id_next;
   logic                 busy_next;
   logic [NREQ-1:0]      pending_next;
   logic [NREQ-1:0]      overflow_next;

   for (genvar i = 0; i < NREQ; i++) begin : g_sync
      req_sync_edge u_sync (
         .out_clk (out_clk),
         .reset   (reset),
         .level   (req_async[i]),
         .rise    (rise[i])
      );
   end

   assign grant_idx = IDW'(rr_pick(MAX_NREQ'(pending), int'(last), NREQ));

   always_ff @(posedge out_clk) begin
      if (reset) begin
         state     <= S_IDLE;
         count     <= '0;
         last      <= IDW'(NREQ - 1);
         strobe    <= '0;
         strobe_id <= '0;
         busy      <= 1'b0;
         pending   <= '0;
         overflow  <= '0;
      end else begin
         state     <= state_next;
         count     <= count_next;
         last      <= last_next;
         strobe    <= strobe_next;
         strobe_id <= id_next;
         busy      <= busy_next;
         pending   <= pending_next;
         overflow  <= overflow_next;
      end
   end

   always_comb begin
      state_next  = state;
      count_next  = count;
      last_next   = last;
      strobe_next = '0;
      id_next     = strobe_id;
      busy_next   = busy;
      grant_mask  = '0;
      case (state)
         S_IDLE: begin
            if (|pending) begin
               grant_mask[grant_idx] = 1'b1;
               id_next    = grant_idx;
               last_next  = grant_idx;
               count_next = delay_cfg[int'(grant_idx)*DELAY_W +: DELAY_W];
               busy_next  = 1'b1;
               state_next = S_COUNT;
            end
         end
         S_COUNT: begin
            if (count != '0) begin
               count_next = count - 1'b1;
            end else begin
               strobe_next[strobe_id] = 1'b1;
               state_next             = S_FIRE;
            end
         end
         S_FIRE: begin
            // no grant here: one idle cycle always separates services
            busy_next  = 1'b0;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // a new edge beats the grant clear; only an edge on a still-queued bit is lost
   always_comb begin
      pending_next  = (pending & ~grant_mask) | rise;
      overflow_next = (overflow & ~{NREQ{ovf_clr}}) | (rise & pending & ~grant_mask);
   end

endmodule

// File: tb/tb_pulse_delay_scheduler.sv
// tb/tb_pulse_delay_scheduler.sv - directed self-checking bench for pulse_delay_scheduler
module tb_pulse_delay_scheduler;

   localparam int NREQ    = 4;
   localparam int DELAY_W = 8;
   localparam int IDW     = 2;

   logic                    out_clk = 1'b0;
   logic                    reset   = 1'b1;
   logic [NREQ-1:0]         req_async = '0;
   logic [NREQ*DELAY_W-1:0] delay_cfg = '0;
   logic                    ovf_clr = 1'b0;
   logic [NREQ-1:0]         strobe;
   logic [IDW-1:0]          strobe_id;
   logic                    busy;
   logic [NREQ-1:0]         pending;
   logic [NREQ-1:0]         overflow;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int idx;
      int d;
      int lat;
      int busy_cyc;
   } vec_t;

   vec_t vecs[4];

   pulse_delay_scheduler #(.NREQ(NREQ), .DELAY_W(DELAY_W), .IDW(IDW)) dut (
      .out_clk   (out_clk),
      .reset     (reset),
      .req_async (req_async),
      .delay_cfg (delay_cfg),
      .ovf_clr   (ovf_clr),
      .strobe    (strobe),
      .strobe_id (strobe_id),
      .busy      (busy),
      .pending   (pending),
      .overflow  (overflow)
   );

   always #5 out_clk = ~out_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic apply_reset();
      @(negedge out_clk);
      reset     = 1'b1;
      req_async = '0;
      ovf_clr   = 1'b0;
      repeat (2) @(negedge out_clk);
      reset = 1'b0;
   endtask

   task automatic set_delay(input int idx, input int d);
      delay_cfg[idx*DELAY_W +: DELAY_W] = DELAY_W'(d);
   endtask

   // cycles from the current sample to the next sample with a strobe
   task automatic wait_strobe(input int budget, output int n);
      n = 0;
      do begin
         @(negedge out_clk);
         n++;
      end while (strobe == '0 && n < budget);
   endtask

   task automatic serve_one(input vec_t v);
      int t;
      int busy_cnt;
      int lat;
      logic seen;
      set_delay(v.idx, v.d);
      req_async[v.idx] = 1'b1;
      t = 0;
      while (!pending[v.idx] && t < 10) begin
         @(negedge out_clk);
         t++;
      end
      check($sformatf("v%0d_pending_rise", v.idx), 32'(pending[v.idx]), 32'd1);
      lat = 0;
      busy_cnt = 0;
      seen = 1'b0;
      while (!seen && lat < 400) begin
         if (busy) busy_cnt++;
         if (strobe != '0) seen = 1'b1;
         else begin
            @(negedge out_clk);
            lat++;
         end
      end
      check($sformatf("v%0d_latency", v.idx), 32'(lat), 32'(v.lat));
      check($sformatf("v%0d_strobe", v.idx), 32'(strobe), 32'(1 << v.idx));
      check($sformatf("v%0d_strobe_id", v.idx), 32'(strobe_id), 32'(v.idx));
      check($sformatf("v%0d_busy_cycles", v.idx), 32'(busy_cnt), 32'(v.busy_cyc));
      @(negedge out_clk);
      check($sformatf("v%0d_strobe_end", v.idx), 32'(strobe), 32'd0);
      check($sformatf("v%0d_busy_end", v.idx), 32'(busy), 32'd0);
      req_async[v.idx] = 1'b0;
      repeat (5) @(negedge out_clk);
   endtask

   initial begin
      int n;
      int t;
      int strobes;
      logic [3:0] exp_pend [4];

      vecs[0] = '{idx: 0, d: 10,  lat: 12,  busy_cyc: 12};
      vecs[1] = '{idx: 1, d: 0,   lat: 2,   busy_cyc: 2};
      vecs[2] = '{idx: 2, d: 3,   lat: 5,   busy_cyc: 5};
      vecs[3] = '{idx: 3, d: 255, lat: 257, busy_cyc: 257};
      exp_pend[0] = 4'b1110;
      exp_pend[1] = 4'b1100;
      exp_pend[2] = 4'b1000;
      exp_pend[3] = 4'b0000;

      apply_reset();
      check("rst_strobe", 32'(strobe), 32'd0);
      check("rst_strobe_id", 32'(strobe_id), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_pending", 32'(pending), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);

      for (int i = 0; i < 4; i++) serve_one(vecs[i]);

      // four simultaneous requests, equal delay
      apply_reset();
      for (int i = 0; i < NREQ; i++) set_delay(i, 5);
      req_async = 4'b1111;
      t = 0;
      while (pending != 4'b1111 && t < 10) begin
         @(negedge out_clk);
         t++;
      end
      check("all4_pending", 32'(pending), 32'hf);
      for (int k = 0; k < 4; k++) begin
         wait_strobe(40, n);
         check($sformatf("all4_gap%0d", k), 32'(n), (k == 0) ? 32'd7 : 32'd8);
         check($sformatf("all4_strobe%0d", k), 32'(strobe), 32'(1 << k));
         check($sformatf("all4_pend%0d", k), 32'(pending), 32'(exp_pend[k]));
      end
      req_async = '0;

      // serve 1 alone, then 1,2,3 together: order 2,3,1
      apply_reset();
      for (int i = 0; i < NREQ; i++) set_delay(i, 2);
      req_async[1] = 1'b1;
      wait_strobe(20, n);
      check("rr_first_id", 32'(strobe_id), 32'd1);
      req_async[1] = 1'b0;
      repeat (6) @(negedge out_clk);
      req_async[3:1] = 3'b111;
      wait_strobe(30, n);
      check("rr_order_a", 32'(strobe), 32'b0100);
      wait_strobe(30, n);
      check("rr_order_b", 32'(strobe), 32'b1000);
      wait_strobe(30, n);
      check("rr_order_c", 32'(strobe), 32'b0010);
      req_async = '0;

      // two edges on requester 2 while 0 is counting
      apply_reset();
      set_delay(0, 20);
      set_delay(2, 1);
      req_async[0] = 1'b1;
      repeat (5) @(negedge out_clk);
      req_async[2] = 1'b1;
      repeat (3) @(negedge out_clk);
      req_async[2] = 1'b0;
      repeat (3) @(negedge out_clk);
      req_async[2] = 1'b1;
      repeat (4) @(negedge out_clk);
      check("ovf_set", 32'(overflow), 32'b0100);
      check("ovf_pending", 32'(pending), 32'b0100);
      wait_strobe(40, n);
      check("ovf_strobe0", 32'(strobe), 32'b0001);
      strobes = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge out_clk);
         if (strobe[2]) strobes++;
      end
      check("ovf_single_strobe2", 32'(strobes), 32'd1);
      check("ovf_sticky", 32'(overflow), 32'b0100);
      ovf_clr = 1'b1;
      @(negedge out_clk);
      ovf_clr = 1'b0;
      check("ovf_cleared", 32'(overflow), 32'd0);
      req_async = '0;

      // reset while counter is at 3 of a D=20 service
      apply_reset();
      set_delay(0, 20);
      set_delay(2, 0);
      req_async[0] = 1'b1;
      t = 0;
      while (!busy && t < 10) begin
         @(negedge out_clk);
         t++;
      end
      check("mid_busy", 32'(busy), 32'd1);
      @(negedge out_clk);
      req_async[1] = 1'b1;
      repeat (3) @(negedge out_clk);
      req_async[1] = 1'b0;
      repeat (3) @(negedge out_clk);
      req_async[1] = 1'b1;
      repeat (10) @(negedge out_clk);
      check("mid_pre_ovf", 32'(overflow), 32'b0010);
      strobes = (strobe != '0) ? 1 : 0;
      reset = 1'b1;
      req_async = '0;
      @(negedge out_clk);
      check("mid_busy_clr", 32'(busy), 32'd0);
      check("mid_pending_clr", 32'(pending), 32'd0);
      check("mid_overflow_clr", 32'(overflow), 32'd0);
      check("mid_id_clr", 32'(strobe_id), 32'd0);
      @(negedge out_clk);
      reset = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (strobe != '0) strobes++;
         @(negedge out_clk);
      end
      check("mid_no_strobe", 32'(strobes), 32'd0);
      req_async = 4'b0101;
      wait_strobe(30, n);
      check("post_rst_first", 32'(strobe), 32'b0001);
      check("post_rst_id", 32'(strobe_id), 32'd0);
      req_async = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
